// File: rtl/barrel_shift_cmd_stage.sv
// Command stage around an external 8-bit shift/rotate network: a command FIFO feeds the
// shifter from its head, and the shifter result is captured in a stall-safe output register.
module barrel_shift_cmd_stage #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_data,
   input  logic [2:0]    in_sel,
   input  logic          in_cntrl,
   output logic [7:0]    sh_x,
   output logic [2:0]    sh_sel,
   output logic          sh_cntrl,
   input  logic [7:0]    sh_z,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_data,
   output logic [2:0]    out_sel,
   output logic          out_cntrl,
   output logic [AW:0]   fill_level
);

   localparam int            CW     = AW + 1;
   localparam logic [AW:0]   C_FULL = CW'(DEPTH);

   logic [7:0]    r_mem_data  [DEPTH];
   logic [2:0]    r_mem_sel   [DEPTH];
   logic          r_mem_cntrl [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_out_valid;
   logic [7:0]    r_out_data;
   logic [2:0]    r_out_sel;
   logic          r_out_cntrl;

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop;
   logic w_slot_free;

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == C_FULL);
   assign w_push      = in_valid & ~w_full;
   assign w_slot_free = ~r_out_valid | out_ready;
   assign w_pop       = ~w_empty & w_slot_free;

   // The head is forced to zero when empty so the shifter sees a quiet input.
   assign sh_x     = w_empty ? 8'h00 : r_mem_data[r_rd_ptr];
   assign sh_sel   = w_empty ? 3'd0  : r_mem_sel[r_rd_ptr];
   assign sh_cntrl = w_empty ? 1'b0  : r_mem_cntrl[r_rd_ptr];

   assign in_ready   = ~w_full;
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_sel    = r_out_sel;
   assign out_cntrl  = r_out_cntrl;
   assign fill_level = r_count;

   always_ff @(posedge clk) begin
      if (w_push && !flush) begin
         r_mem_data[r_wr_ptr]  <= in_data;
         r_mem_sel[r_wr_ptr]   <= in_sel;
         r_mem_cntrl[r_wr_ptr] <= in_cntrl;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Output register only changes on a pop or on acceptance; otherwise it stays frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= 8'h00;
         r_out_sel   <= 3'd0;
         r_out_cntrl <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_pop) begin
         r_out_valid <= 1'b1;
         r_out_data  <= sh_z;
         r_out_sel   <= sh_sel;
         r_out_cntrl <= sh_cntrl;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_barrel_shift_cmd_stage.sv
// Directed bench for barrel_shift_cmd_stage with a behavioural shifter and a result scoreboard.
module tb_barrel_shift_cmd_stage;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [2:0] in_sel;
   logic       in_cntrl;
   logic [7:0] sh_x;
   logic [2:0] sh_sel;
   logic       sh_cntrl;
   logic [7:0] sh_z;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] out_sel;
   logic       out_cntrl;
   logic [2:0] fill_level;

   logic [11:0] exp_q[$];
   int          n_checks;
   int          n_fail;
   int          n_out;

   barrel_shift_cmd_stage #(.DEPTH(4), .AW(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .in_cntrl(in_cntrl),
      .sh_x(sh_x), .sh_sel(sh_sel), .sh_cntrl(sh_cntrl), .sh_z(sh_z),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sel(out_sel), .out_cntrl(out_cntrl),
      .fill_level(fill_level)
   );

   // External shifter: rotate left when cntrl=1, zero-fill left shift otherwise.
   assign sh_z = sh_cntrl ? ((sh_x << sh_sel) | (sh_x >> (4'd8 - {1'b0, sh_sel})))
                          : (sh_x << sh_sel);

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ref_shift(input logic [7:0] x, input logic [2:0] sel,
                                            input logic cntrl);
      logic [7:0] v;
      v = x;
      for (int k = 0; k < int'(sel); k++) v = cntrl ? {v[6:0], v[7]} : {v[6:0], 1'b0};
      return v;
   endfunction

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] s, input logic c);
      in_valid = v;
      in_data  = d;
      in_sel   = s;
      in_cntrl = c;
   endtask

   // Holds a command until the DUT accepts it, with a bounded wait.
   task automatic push_cmd(input logic [7:0] d, input logic [2:0] s, input logic c);
      logic done;
      done = 1'b0;
      drive(1'b1, d, s, c);
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         tick();
      end
      if (!done) check("push_timeout", 12'd0, 12'd1);
      in_valid = 1'b0;
   endtask

   // scoreboard: retire the presented result first, then record any newly accepted command
   always @(negedge clk) begin
      if (rst_n && !flush) begin
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) check("unexpected_out", {out_cntrl, out_sel, out_data}, 12'hFFF);
            else check("out_result", {out_cntrl, out_sel, out_data}, exp_q.pop_front());
         end
         if (in_valid && in_ready)
            exp_q.push_back({in_cntrl, in_sel, ref_shift(in_data, in_sel, in_cntrl)});
      end
   end

   initial begin : main
      logic [7:0] d3 [6];
      logic [2:0] s3 [6];
      logic       c3 [6];
      logic [7:0] tbl [8];
      int         out_snap;

      n_checks = 0; n_fail = 0; n_out = 0;
      flush = 1'b0; out_ready = 1'b1;
      rst_n = 1'b0;

      // 1: reset held while a command is offered
      drive(1'b1, 8'hAA, 3'd1, 1'b0);
      repeat (3) tick();
      check("rst_fill", 12'(fill_level), 12'd0);
      check("rst_out_valid", 12'(out_valid), 12'd0);
      check("rst_in_ready", 12'(in_ready), 12'd1);
      check("rst_out_data", 12'(out_data), 12'd0);
      check("rst_sh_x", 12'(sh_x), 12'd0);
      rst_n = 1'b1;
      in_valid = 1'b0;
      repeat (3) tick();
      check("post_rst_fill", 12'(fill_level), 12'd0);
      check("post_rst_valid", 12'(out_valid), 12'd0);
      check("post_rst_nout", 12'(n_out), 12'd0);

      // 2: single shift then single rotate, latency check
      drive(1'b1, 8'hCC, 3'd3, 1'b0);
      tick();
      in_valid = 1'b0;
      check("lat_sh_x", 12'(sh_x), 12'hCC);
      check("lat_sh_sel", 12'(sh_sel), 12'd3);
      check("lat_fill", 12'(fill_level), 12'd1);
      check("lat_no_valid_yet", 12'(out_valid), 12'd0);
      tick();
      check("shift_valid", 12'(out_valid), 12'd1);
      check("shift_data", 12'(out_data), 12'h60);
      check("shift_fill", 12'(fill_level), 12'd0);
      tick();
      drive(1'b1, 8'hCC, 3'd3, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      check("rot_data", 12'(out_data), 12'h66);
      check("rot_cntrl", 12'(out_cntrl), 12'd1);
      tick();
      check("rot_valid_clear", 12'(out_valid), 12'd0);
      check("rot_data_hold", 12'(out_data), 12'h66);

      // 3: back-pressure fills the FIFO, sixth command stalls, then drain
      for (int i = 0; i < 6; i++) begin
         d3[i] = 8'($urandom_range(0, 255));
         s3[i] = 3'($urandom_range(0, 7));
         c3[i] = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_cmd(d3[i], s3[i], c3[i]);
      drive(1'b1, d3[5], s3[5], c3[5]);
      repeat (2) tick();
      check("full_in_ready", 12'(in_ready), 12'd0);
      check("full_fill", 12'(fill_level), 12'd4);
      check("full_out_valid", 12'(out_valid), 12'd1);
      check("full_out_frozen", 12'(out_data), 12'(ref_shift(d3[0], s3[0], c3[0])));
      check("full_head", 12'(sh_x), 12'(d3[1]));
      out_ready = 1'b1;
      push_cmd(d3[5], s3[5], c3[5]);
      repeat (8) tick();
      check("drain_fill", 12'(fill_level), 12'd0);
      check("drain_q_empty", 12'(exp_q.size()), 12'd0);

      // 4: continuous rotate stream of 8'h81 at one command per cycle
      tbl[0] = 8'h81; tbl[1] = 8'h03; tbl[2] = 8'h06; tbl[3] = 8'h0C;
      tbl[4] = 8'h18; tbl[5] = 8'h30; tbl[6] = 8'h60; tbl[7] = 8'hC0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i < 8) drive(1'b1, 8'h81, 3'(i), 1'b1);
         else in_valid = 1'b0;
         tick();
         check("stream_fill_le1", 12'(fill_level <= 3'd1), 12'd1);
         if (i >= 1 && i <= 8) begin
            check("stream_valid", 12'(out_valid), 12'd1);
            check("stream_data", 12'(out_data), 12'(tbl[i-1]));
         end
      end
      tick();

      // random traffic with random back-pressure
      for (int i = 0; i < 40; i++) begin
         drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (8) tick();
      check("rand_q_empty", 12'(exp_q.size()), 12'd0);

      // 5: flush with three queued plus a pending result
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_cmd(8'(8'h11 * (i + 1)), 3'(i), 1'b0);
      check("preflush_fill", 12'(fill_level), 12'd3);
      check("preflush_valid", 12'(out_valid), 12'd1);
      flush = 1'b1;
      drive(1'b1, 8'hEE, 3'd2, 1'b1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      check("flush_valid", 12'(out_valid), 12'd0);
      check("flush_fill", 12'(fill_level), 12'd0);
      check("flush_in_ready", 12'(in_ready), 12'd1);
      out_ready = 1'b1;
      out_snap = n_out;
      push_cmd(8'h5A, 3'd4, 1'b1);
      repeat (5) tick();
      check("post_flush_count", 12'(n_out - out_snap), 12'd1);
      check("post_flush_q", 12'(exp_q.size()), 12'd0);

      // 6: asynchronous reset between edges during a stream
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'($urandom_range(0, 255)), 3'(i), 1'b0);
         tick();
      end
      out_ready = 1'b0;
      drive(1'b1, 8'h77, 3'd1, 1'b0);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", 12'(out_valid), 12'd0);
      check("async_fill", 12'(fill_level), 12'd0);
      in_valid = 1'b0;
      exp_q.delete();
      out_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      out_snap = n_out;
      repeat (5) tick();
      check("post_async_nout", 12'(n_out - out_snap), 12'd0);
      check("post_async_fill", 12'(fill_level), 12'd0);
      check("post_async_valid", 12'(out_valid), 12'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
